// File: rtl/pc_sequenciador_pkg.sv
// Shared CPU definitions: sequencer state encodings and default datapath width.
package cpu_defs;

    localparam int DATA_WIDTH_PADRAO = 32;

    typedef enum logic [1:0] {
        EST_RUN     = 2'b00,
        EST_WAIT_IN = 2'b01,
        EST_HALTED  = 2'b10
    } estado_t;

endpackage

// File: rtl/pc_sequenciador_detector_borda.sv
// 1-bit synchronous rising-edge detector; the previous level is registered so a
// held input produces a single-cycle pulse.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic borda
);

    logic anterior_r;

    // Remember last cycle's input level.
    always_ff @(posedge clock) begin
        if (reset) begin
            anterior_r <= 1'b0;
        end else begin
            anterior_r <= entrada;
        end
    end

    assign borda = entrada & ~anterior_r;

endmodule

// File: rtl/pc_sequenciador.sv
// PC register and fetch sequencer with IN/HALT stall states.
// Optional retired-instruction counter enabled by macro PC_CONTADOR_INSTR_EN.
module pc_sequenciador
    import cpu_defs::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_PADRAO,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] alvo_jump,
    input  logic [DATA_WIDTH-1:0] alvo_jr,
    input  logic                  sel_jump,
    input  logic                  sel_jr,
    input  logic                  sel_branch,
    input  logic                  cond_branch,
    input  logic                  sel_halt,
    input  logic                  sel_in,
    input  logic                  in_valido,
    input  logic                  retomar,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  in_pronto,
    output logic                  stall,
    output logic [1:0]            estado,
    output logic [31:0]           contador_instr
);

    estado_t               estado_r;
    estado_t               estado_prox_s;
    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] pc_prox_s;
    logic [DATA_WIDTH-1:0] pc_mais_um_s;
    logic                  in_pronto_s;
    logic                  stall_s;
    logic                  borda_retomar_s;

    detector_borda u_borda_retomar (
        .clock   (clock),
        .reset   (reset),
        .entrada (retomar),
        .borda   (borda_retomar_s)
    );

    assign pc_mais_um_s = pc_r + DATA_WIDTH'(1);

    // Next-PC priority, state transitions and stall/handshake decode.
    always_comb begin
        pc_prox_s     = pc_r;
        estado_prox_s = estado_r;
        in_pronto_s   = 1'b0;
        stall_s       = 1'b0;
        case (estado_r)
            EST_RUN: begin
                if (sel_jump) begin
                    pc_prox_s = alvo_jump;
                end else if (sel_jr) begin
                    pc_prox_s = alvo_jr;
                end else if (sel_branch && cond_branch) begin
                    pc_prox_s = alvo_jump;
                end else if (sel_halt) begin
                    estado_prox_s = EST_HALTED;
                end else if (sel_in) begin
                    if (in_valido) begin
                        in_pronto_s = 1'b1;
                        pc_prox_s   = pc_mais_um_s;
                    end else begin
                        stall_s       = 1'b1;
                        estado_prox_s = EST_WAIT_IN;
                    end
                end else begin
                    pc_prox_s = pc_mais_um_s;
                end
            end
            EST_WAIT_IN: begin
                // Drop stall on the accept cycle so the IN register write commits.
                if (in_valido) begin
                    in_pronto_s   = 1'b1;
                    pc_prox_s     = pc_mais_um_s;
                    estado_prox_s = EST_RUN;
                end else begin
                    stall_s = 1'b1;
                end
            end
            EST_HALTED: begin
                stall_s = 1'b1;
                if (borda_retomar_s) begin
                    pc_prox_s     = pc_mais_um_s;
                    estado_prox_s = EST_RUN;
                end else begin
                    pc_prox_s = pc_r;
                end
            end
            default: begin
                estado_prox_s = EST_RUN;
            end
        endcase
    end

    // PC and state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r     <= RESET_PC;
            estado_r <= EST_RUN;
        end else begin
            pc_r     <= pc_prox_s;
            estado_r <= estado_prox_s;
        end
    end

`ifdef PC_CONTADOR_INSTR_EN
    logic [31:0] contador_r;

    // Count every clock in which the core is not frozen.
    always_ff @(posedge clock) begin
        if (reset) begin
            contador_r <= 32'd0;
        end else if (!stall_s) begin
            contador_r <= contador_r + 32'd1;
        end else begin
            contador_r <= contador_r;
        end
    end

    assign contador_instr = contador_r;
`else
    assign contador_instr = 32'd0;
`endif

    assign pc        = pc_r;
    assign estado    = estado_r;
    assign in_pronto = in_pronto_s & ~reset;
    assign stall     = stall_s & ~reset;

endmodule

// File: tb/tb_pc_sequenciador.sv
// Directed-vector bench for pc_sequenciador with a queue-based scoreboard.
module tb_pc_sequenciador;

    localparam logic [8:0] RST = 9'h100;
    localparam logic [8:0] JMP = 9'h080;
    localparam logic [8:0] JR  = 9'h040;
    localparam logic [8:0] BR  = 9'h020;
    localparam logic [8:0] CB  = 9'h010;
    localparam logic [8:0] HLT = 9'h008;
    localparam logic [8:0] INN = 9'h004;
    localparam logic [8:0] VAL = 9'h002;
    localparam logic [8:0] RET = 9'h001;
    localparam logic [8:0] NON = 9'h000;

    typedef struct {
        logic [8:0]  ctl;
        logic [31:0] aj;
        logic [31:0] ajr;
        bit          chk;
        logic [31:0] epc;
        logic [1:0]  eest;
        logic        estl;
        logic        epr;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] epc;
        logic [1:0]  eest;
        logic        estl;
        logic        epr;
        logic [31:0] ecnt;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] alvo_jump, alvo_jr;
    logic        sel_jump, sel_jr, sel_branch, cond_branch, sel_halt, sel_in;
    logic        in_valido, retomar;
    logic [31:0] pc;
    logic        in_pronto, stall;
    logic [1:0]  estado;
    logic [31:0] contador_instr;

    vec_t  tab[$];
    exp_t  fila[$];
    int    checks = 0;
    int    errors = 0;
    bit    fim = 1'b0;

    pc_sequenciador #(.DATA_WIDTH(32), .RESET_PC(32'd0)) dut (
        .clock          (clock),
        .reset          (reset),
        .alvo_jump      (alvo_jump),
        .alvo_jr        (alvo_jr),
        .sel_jump       (sel_jump),
        .sel_jr         (sel_jr),
        .sel_branch     (sel_branch),
        .cond_branch    (cond_branch),
        .sel_halt       (sel_halt),
        .sel_in         (sel_in),
        .in_valido      (in_valido),
        .retomar        (retomar),
        .pc             (pc),
        .in_pronto      (in_pronto),
        .stall          (stall),
        .estado         (estado),
        .contador_instr (contador_instr)
    );

    always #5 clock = ~clock;

    task automatic add(input logic [8:0] ctl, input logic [31:0] aj, input logic [31:0] ajr,
                       input bit chk, input logic [31:0] epc, input logic [1:0] eest,
                       input logic estl, input logic epr);
        vec_t v;
        v.ctl = ctl; v.aj = aj; v.ajr = ajr; v.chk = chk;
        v.epc = epc; v.eest = eest; v.estl = estl; v.epr = epr;
        tab.push_back(v);
    endtask

    task automatic cmp(input int idx, input string campo, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL v%0d_%s actual=%h required=%h", idx, campo, act, req);
        end
    endtask

    // Monitor: sample away from the active edge and pop the scoreboard.
    always @(negedge clock) begin
        if (fila.size() > 0) begin
            exp_t e;
            e = fila.pop_front();
            cmp(e.idx, "pc", pc, e.epc);
            cmp(e.idx, "estado", {30'd0, estado}, {30'd0, e.eest});
            cmp(e.idx, "stall", {31'd0, stall}, {31'd0, e.estl});
            cmp(e.idx, "in_pronto", {31'd0, in_pronto}, {31'd0, e.epr});
            cmp(e.idx, "contador", contador_instr, e.ecnt);
        end
    end

    initial begin
        logic [31:0] cnt;
        exp_t        e;
        cnt = 32'd0;
        {reset, sel_jump, sel_jr, sel_branch, cond_branch, sel_halt, sel_in, in_valido, retomar} = 9'h100;
        alvo_jump = 32'd0;
        alvo_jr   = 32'd0;

        add(RST,            32'd0,  32'd0, 1'b0, 32'd0,  2'b00, 1'b0, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd0,  2'b00, 1'b0, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd1,  2'b00, 1'b0, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd2,  2'b00, 1'b0, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd3,  2'b00, 1'b0, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd4,  2'b00, 1'b0, 1'b0);
        add(JMP,            32'd40, 32'd0, 1'b1, 32'd5,  2'b00, 1'b0, 1'b0);
        add(BR,             32'd99, 32'd0, 1'b1, 32'd40, 2'b00, 1'b0, 1'b0);
        add(BR | CB,        32'd10, 32'd0, 1'b1, 32'd41, 2'b00, 1'b0, 1'b0);
        add(JMP,            32'd7,  32'd0, 1'b1, 32'd10, 2'b00, 1'b0, 1'b0);
        add(INN,            32'd0,  32'd0, 1'b1, 32'd7,  2'b00, 1'b1, 1'b0);
        add(INN | JMP | RET, 32'd50, 32'd0, 1'b1, 32'd7, 2'b01, 1'b1, 1'b0);
        add(INN,            32'd0,  32'd0, 1'b1, 32'd7,  2'b01, 1'b1, 1'b0);
        add(INN | VAL,      32'd0,  32'd0, 1'b1, 32'd7,  2'b01, 1'b0, 1'b1);
        add(INN | VAL,      32'd0,  32'd0, 1'b1, 32'd8,  2'b00, 1'b0, 1'b1);
        add(HLT | INN | VAL, 32'd0, 32'd0, 1'b1, 32'd9,  2'b00, 1'b0, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd9,  2'b10, 1'b1, 1'b0);
        add(VAL | JMP,      32'd60, 32'd0, 1'b1, 32'd9,  2'b10, 1'b1, 1'b0);
        add(RET,            32'd0,  32'd0, 1'b1, 32'd9,  2'b10, 1'b1, 1'b0);
        add(RET | HLT,      32'd0,  32'd0, 1'b1, 32'd10, 2'b00, 1'b0, 1'b0);
        add(RET,            32'd0,  32'd0, 1'b1, 32'd10, 2'b10, 1'b1, 1'b0);
        add(RET,            32'd0,  32'd0, 1'b1, 32'd10, 2'b10, 1'b1, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd10, 2'b10, 1'b1, 1'b0);
        add(RET,            32'd0,  32'd0, 1'b1, 32'd10, 2'b10, 1'b1, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd11, 2'b00, 1'b0, 1'b0);
        add(JMP,            32'hFFFF_FFFF, 32'd0, 1'b1, 32'd12, 2'b00, 1'b0, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd0,  2'b00, 1'b0, 1'b0);
        add(JR | BR | CB,   32'd5,  32'h123, 1'b1, 32'd1, 2'b00, 1'b0, 1'b0);
        add(JMP | JR,       32'd20, 32'd30, 1'b1, 32'h123, 2'b00, 1'b0, 1'b0);
        add(INN,            32'd0,  32'd0, 1'b1, 32'd20, 2'b00, 1'b1, 1'b0);
        add(RST | VAL,      32'd0,  32'd0, 1'b1, 32'd20, 2'b01, 1'b0, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd0,  2'b00, 1'b0, 1'b0);
        add(NON,            32'd0,  32'd0, 1'b1, 32'd1,  2'b00, 1'b0, 1'b0);

        for (int i = 0; i < tab.size(); i++) begin
            @(posedge clock);
            #1;
            {reset, sel_jump, sel_jr, sel_branch, cond_branch, sel_halt, sel_in, in_valido, retomar} = tab[i].ctl;
            alvo_jump = tab[i].aj;
            alvo_jr   = tab[i].ajr;
            if (tab[i].chk) begin
                e.idx  = i;
                e.epc  = tab[i].epc;
                e.eest = tab[i].eest;
                e.estl = tab[i].estl;
                e.epr  = tab[i].epr;
`ifdef PC_CONTADOR_INSTR_EN
                e.ecnt = cnt;
`else
                e.ecnt = 32'd0;
`endif
                fila.push_back(e);
            end
            if (tab[i].ctl[8]) begin
                cnt = 32'd0;
            end else if (!tab[i].estl) begin
                cnt = cnt + 32'd1;
            end
        end

        @(posedge clock);
        #1;
        {reset, sel_jump, sel_jr, sel_branch, cond_branch, sel_halt, sel_in, in_valido, retomar} = NON;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (fila.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", fila.size());
        end
        fim = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        if (!fim) begin
            $display("FAIL timeout actual=running required=finished");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/pc_sequenciador.md
Name: pc_sequenciador

Overview:
- Program-counter register and fetch sequencer for the single-cycle lab CPU; the consuming end of the next-PC selection path.
- Holds the current PC, applies the jump / jump-register / taken-branch / halt / in / increment decision each clock, and owns the stall states for HALT and IN.
- Performs the IN handshake with the input peripheral (valid/ready) and the resume handshake after HALT.
- Sits between the control unit and instruction memory; its output `pc` addresses instruction memory directly.

Parameters:
- DATA_WIDTH, 32, width of the PC and the target inputs.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- alvo_jump  in  DATA_WIDTH  target for J/JAL and for taken branches.
- alvo_jr  in  DATA_WIDTH  register target for JR.
- sel_jump  in  1  current instruction is J or JAL.
- sel_jr  in  1  current instruction is JR.
- sel_branch  in  1  current instruction is a branch.
- cond_branch  in  1  branch condition true (ALU flag).
- sel_halt  in  1  current instruction is HALT.
- sel_in  in  1  current instruction is IN.
- in_valido  in  1  input peripheral has data on its bus.
- retomar  in  1  resume pulse (board button, already debounced).
- pc  out  DATA_WIDTH  registered current PC.
- in_pronto  out  1  IN data accepted this cycle (combinational).
- stall  out  1  core frozen; register file and memory writes must be gated.
- estado  out  2  00 RUN, 01 WAIT_IN, 10 HALTED.
- contador_instr  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, estado=RUN, in_pronto=0, stall=0, contador_instr=0. Reset overrides every other input, in any state.
- RUN: next PC uses fixed priority:
  - sel_jump → alvo_jump;
  - else sel_jr → alvo_jr;
  - else sel_branch&&cond_branch → alvo_jump;
  - else sel_halt → pc holds, go HALTED;
  - else sel_in → if in_valido then in_pronto=1 and pc+1 (stay RUN), else pc holds and go WAIT_IN;
  - else pc+1.
  - stall=0 in RUN, except stall=1 in the cycle sel_in is seen with in_valido=0.
- WAIT_IN: pc holds, stall=1.
  - On in_valido=1: in_pronto=1 that cycle, pc<=pc+1, next state RUN, stall=0 in that cycle so the register-file write of the IN data commits.
  - sel_* inputs are ignored in WAIT_IN.
- HALTED: pc holds, stall=1, in_valido is ignored.
  - On retomar=1: pc<=pc+1, next state RUN.
  - retomar held for several cycles resumes only once; a rising-edge detect is registered internally.
  - retomar already high on HALT entry does not resume until it has been seen low.
- Latency: the next PC is visible one clock after the decision; the stall exit (WAIT_IN or HALTED to RUN) takes one clock.
- Arithmetic: pc+1 is modulo 2^DATA_WIDTH; all-ones wraps to 0 with no flag.
- in_pronto is asserted only in a cycle that advances the PC past an IN, and never in HALTED.
- Simultaneous events:
  - sel_halt and sel_in together: halt wins.
  - retomar in RUN or WAIT_IN: ignored.
  - Reset in WAIT_IN or HALTED: returns to RUN at RESET_PC, with no in_pronto pulse.

Optional Feature:
- Macro PC_CONTADOR_INSTR_EN.
- Defined: contador_instr increments by 1 (wrapping at 2^32) on every clock where the PC advances (stall=0, not reset), including jumps and branches.
- Undefined: no counter register is built and contador_instr is tied to 0.

Decomposition:
- Shared package (or include file) cpu_defs: estado encodings (EST_RUN=2'b00, EST_WAIT_IN=2'b01, EST_HALTED=2'b10) and DATA_WIDTH default.
- One sub-module is natural: detector_borda (1-bit synchronous rising-edge detector with reset) for retomar.
- The next-PC priority logic stays inline.

Test Plan:
- Reset then 3 idle clocks with no sel → pc 0,1,2,3; estado 00; stall 0.
- At pc=5, sel_jump=1, alvo_jump=40 → pc=40 next clock; at pc=40, sel_branch=1, cond_branch=0 → pc=41; then cond_branch=1, alvo_jump=10 → pc=10.
- At pc=7, sel_in=1, in_valido=0 for 3 clocks then 1 → pc stays 7, estado 01, stall 1; in_pronto pulses once; next pc=8, estado 00.
- At pc=9, sel_halt=1; retomar held high 4 clocks after 2 halted clocks → pc stays 9 until edge, then single step to 10, estado 00; no further increments from the held level.
- pc=32'hFFFF_FFFF with no sel → pc=0; with PC_CONTADOR_INSTR_EN defined, contador_instr counts only non-stalled cycles.
- Reset asserted while in WAIT_IN with in_valido=1 → pc=RESET_PC, estado 00, in_pronto 0.
